// File: rtl/matmul_sequencer.sv
// Memory-side matrix multiplier: reads A and B (N x N, row-major), writes C = A x B.
// Optional MATMUL_SAT_EN: wide accumulator with signed-32 saturation on write-back.
module matmul_sequencer #(
    parameter int unsigned N      = 3,
    parameter int unsigned AW     = 17,
    parameter int unsigned DW     = 32,
    parameter int unsigned A_BASE = 0,
    parameter int unsigned B_BASE = 64,
    parameter int unsigned C_BASE = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          memread,
    output logic          memwrite,
    output logic [AW-1:0] address,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned IW = $clog2(N + 1);
`ifdef MATMUL_SAT_EN
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned AccW = 2 * DW + 8;
    localparam logic signed [AccW-1:0] SatMax = {{(AccW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = {{(AccW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`else
    localparam int unsigned AccW = DW;
`endif

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StMac, StWr, StDone} state_e;

    state_e                 state_q;
    logic [IW-1:0]          i_q, j_q, k_q;
    logic signed [AccW-1:0] acc_q;
    logic signed [DW-1:0]   a_reg_q;
    logic                   armed_q;

    logic signed [AccW-1:0] acc_next;
    logic [DW-1:0]          result;
    logic [IW-1:0]          i_nxt, j_nxt, k_inc;
    logic                   k_last, last_elem;
    logic [AW-1:0]          a_addr_k, a_addr_wr, b_addr, c_addr;
`ifdef MATMUL_SAT_EN
    logic signed [PW-1:0]   prod;
`endif

    // Full-precision address, silently truncated to AW bits.
    function automatic logic [AW-1:0] word_addr(input int unsigned base,
                                                 input logic [IW-1:0] row,
                                                 input logic [IW-1:0] col);
        longint unsigned full;
        full = 64'(base) + 64'(row) * 64'(N) + 64'(col);
        return full[AW-1:0];
    endfunction

    always_comb begin
`ifdef MATMUL_SAT_EN
        prod     = PW'(a_reg_q) * PW'($signed(mem_rdata));
        acc_next = acc_q + AccW'(prod);
        if (acc_next > SatMax) begin
            result = {1'b0, {(DW-1){1'b1}}};
        end else if (acc_next < SatMin) begin
            result = {1'b1, {(DW-1){1'b0}}};
        end else begin
            result = acc_next[DW-1:0];
        end
`else
        acc_next = acc_q + a_reg_q * $signed(mem_rdata);
        result   = acc_next;
`endif
        k_last    = (k_q == IW'(N - 1));
        k_inc     = k_q + IW'(1);
        last_elem = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));
        if (j_q == IW'(N - 1)) begin
            j_nxt = '0;
            i_nxt = i_q + IW'(1);
        end else begin
            j_nxt = j_q + IW'(1);
            i_nxt = i_q;
        end
        a_addr_k  = word_addr(A_BASE, i_q, k_inc);
        a_addr_wr = word_addr(A_BASE, i_nxt, '0);
        b_addr    = word_addr(B_BASE, k_q, j_q);
        c_addr    = word_addr(C_BASE, i_q, j_q);
    end

    // Outputs are registered on entry to each state so strobes, address and data
    // are stable for the whole cycle in which the state is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            address   <= '0;
            mem_wdata <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            a_reg_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            // armed_q blocks a start coinciding with reset release.
            armed_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (start && armed_q) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                        busy    <= 1'b1;
                        memread <= 1'b1;
                        address <= word_addr(A_BASE, '0, '0);
                        state_q <= StRdA;
                    end
                end
                StRdA: begin
                    memread <= 1'b1;
                    address <= b_addr;
                    state_q <= StRdB;
                end
                StRdB: begin
                    a_reg_q <= $signed(mem_rdata);
                    memread <= 1'b0;
                    state_q <= StMac;
                end
                StMac: begin
                    acc_q <= acc_next;
                    if (k_last) begin
                        k_q       <= '0;
                        memwrite  <= 1'b1;
                        address   <= c_addr;
                        mem_wdata <= result;
                        state_q   <= StWr;
                    end else begin
                        k_q     <= k_inc;
                        memread <= 1'b1;
                        address <= a_addr_k;
                        state_q <= StRdA;
                    end
                end
                StWr: begin
                    memwrite <= 1'b0;
                    acc_q    <= '0;
                    i_q      <= i_nxt;
                    j_q      <= j_nxt;
                    if (last_elem) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        memread <= 1'b1;
                        address <= a_addr_wr;
                        state_q <= StRdA;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Memory-side master for the main memory block: reads two N×N signed 32-bit matrices, computes C = A×B, and writes C back to the output region.
- Drives the memory's memread/memwrite/address/data_in and consumes its data_out.
- Sits between the processor control, which issues `start`, and main memory.
- Row-major word addressing; one memory access per cycle.

Parameters:
- N, 3, matrix dimension; legal range 2..8.
- AW, 17, memory address width.
- DW, 32, data width.
- A_BASE, 0, word address of A[0][0].
- B_BASE, 64, word address of B[0][0].
- C_BASE, 128, word address of C[0][0].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse in DONE state.
- memread  out  1  read strobe to memory.
- memwrite  out  1  write strobe to memory.
- address  out  AW  word address to memory.
- mem_wdata  out  DW  write data to memory (data_in of memory).
- mem_rdata  in  DW  read data from memory (data_out of memory); valid exactly 1 cycle after memread.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n, asynchronous, active-low.
- Reset (async):
  - state=IDLE; busy=0, done=0, memread=0, memwrite=0, address=0, mem_wdata=0.
  - Indices i, j, k = 0; acc = 0.
- Reset mid-operation: strobes drop immediately; no partial write completes; C contents are undefined.
- States: IDLE, RD_A, RD_B, MAC, WR, DONE.
- IDLE: start=1 → RD_A; clear i, j, k, acc.
- RD_A: memread=1, address = A_BASE + i*N + k → RD_B.
- RD_B:
  - Capture a_reg = mem_rdata.
  - memread=1, address = B_BASE + k*N + j → MAC.
- MAC:
  - memread=0.
  - acc += a_reg × mem_rdata (signed).
  - If k==N-1: k=0 → WR. Else: k++ → RD_A.
- WR:
  - memwrite=1, address = C_BASE + i*N + j, mem_wdata = result(acc).
  - Clear acc. Advance j; on j wrap to 0 advance i.
  - If i==N-1 and j==N-1 before the advance → DONE, else → RD_A.
- DONE: done=1, busy=0 in the same cycle → IDLE.
- Strobe rules: memread and memwrite are never high together; address and data are stable for the whole strobe cycle.
- Address arithmetic: computed at full precision, truncated to AW bits; wrap-around is not flagged.
- Latency: exactly N*N*(3N+1) cycles in RD_A..WR, plus 1 DONE cycle. For N=3 that is 90+1.
- Simultaneous events: start while busy or in DONE is ignored, not queued. start in the same cycle as rst_n deassertion is ignored.
- Arithmetic without the feature: signed 32×32 products; acc keeps the low 32 bits (mod 2^32 wrap).

Optional Feature:
- Macro MATMUL_SAT_EN.
- Defined:
  - Products kept at 64 bits; acc is 72-bit signed.
  - On WR, result clamps to 0x7FFFFFFF or 0x80000000 when out of signed-32 range, else the low 32 bits.
- Undefined: wrap behaviour as above; acc is 32-bit.

Test Plan:
- Functional product:
  - A = 1..9 row-major at 0..8; B = {1,0,1,0,1,0,1,0,1} at 64..72; pulse start.
  - Expect C at 128..136 = {4,2,4,10,5,10,16,8,16}.
  - Expect done one cycle after the 9th write, busy high exactly 90 cycles.
- Bus protocol:
  - Count 54 memread strobes and 9 memwrite strobes.
  - Never both high in the same cycle.
  - First three addresses are 0, 64, then no strobe (MAC).
- Start while busy: pulse start again at cycle 20 → ignored; exactly 9 writes; single done pulse.
- Reset mid-op:
  - Assert rst_n=0 at cycle 40 → all outputs 0 asynchronously.
  - After release, start → full correct result {4,2,4,...}.
- Overflow, A all 0x40000000, B all 2:
  - Without MATMUL_SAT_EN: every C = 0x80000000.
  - With MATMUL_SAT_EN: every C = 0x7FFFFFFF.
- Negative values: A = identity × −5, B = 1..9 → C = {−5,−10,...,−45}, i.e. 0xFFFFFFFB first.
